// File: rtl/spi_req_arbiter_if.sv
// Bundle between the round-robin SPI arbiter, its requesters and the SPI
// parent transmit engine.
//   slave  : the arbiter side (takes requests, drives grant/ack and the engine)
//   master : the environment side (requesters plus the SPI engine)
interface spi_req_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 12
);
   // requester side
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        grant;
   logic [NUM_REQ-1:0]        ack;

   // SPI engine side
   logic                      spi_start;
   logic [DATA_W-1:0]         spi_data;
   logic                      spi_busy;
   logic                      spi_done;

   // status
   logic                      arb_busy;
   logic                      err;

   modport slave (
      input  req, req_data, spi_busy, spi_done,
      output grant, ack, spi_start, spi_data, arb_busy, err
   );

   modport master (
      output req, req_data, spi_busy, spi_done,
      input  grant, ack, spi_start, spi_data, arb_busy, err
   );
endinterface

// File: rtl/spi_req_arbiter.sv
// Round-robin scheduler sharing one SPI parent transmit engine between
// NUM_REQ requesters. The winner's payload is latched, a one-cycle start is
// issued once the engine is idle, the engine's done pulse is turned into a
// one-cycle ack to the owner, and a GAP_CYCLES idle gap (SS high) is enforced
// before the next transaction.
//
// Optional build macro TIMEOUT_EN: adds a WAIT watchdog. After TIMEOUT_CYCLES
// cycles in WAIT without spi_done, err pulses for one cycle, the grant is
// dropped without an ack and the arbiter moves on through GAP. Without the
// macro WAIT waits indefinitely and err is tied low.
module spi_req_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int DATA_W         = 12,
   parameter int GAP_CYCLES     = 200,
   parameter int TIMEOUT_CYCLES = 20000
) (
   input logic             clk,
   input logic             rst,
   spi_req_arbiter_if.slave bus
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int GAP_W = $clog2(GAP_CYCLES + 2);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      GAP   = 2'd3
   } state_t;

   state_t state;
   state_t state_nxt;

   // registered outputs and datapath
   logic [NUM_REQ-1:0] grant_reg, grant_nxt;
   logic [NUM_REQ-1:0] ack_reg,   ack_nxt;
   logic               start_reg, start_nxt;
   logic               err_reg,   err_nxt;
   logic [DATA_W-1:0]  data_reg,  data_nxt;
   logic [IDX_W-1:0]   cur_reg,   cur_nxt;
   logic [IDX_W-1:0]   last_reg,  last_nxt;
   logic [GAP_W-1:0]   gap_cnt,   gap_nxt;

   // arbitration result
   logic               any_req;
   logic [IDX_W-1:0]   win_idx;
   logic [IDX_W-1:0]   scan_idx;

   // completion qualifiers
   logic               done_ok;
   logic               timeout_hit;

   // Requester index 'step' positions after 'base', wrapping at NUM_REQ.
   function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base,
                                                  input int step);
      rr_index = IDX_W'((int'(base) + step) % NUM_REQ);
   endfunction

   // The done pulse cannot belong to this transaction while our own start
   // pulse is still on the wire, so it is ignored in that cycle.
   assign done_ok = (state == WAIT) && bus.spi_done && !start_reg;

   // Round-robin search: first set request after the last served requester.
   // Scanning from the far end lets the nearest candidate overwrite the rest.
   always_comb begin
      any_req  = 1'b0;
      win_idx  = '0;
      scan_idx = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         scan_idx = rr_index(last_reg, i);
         if (bus.req[scan_idx]) begin
            any_req = 1'b1;
            win_idx = scan_idx;
         end
      end
   end

`ifdef TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   logic [WD_W-1:0] wd_cnt;

   // Watchdog: counts cycles spent in WAIT, cleared whenever WAIT is left.
   always_ff @(posedge clk) begin
      if (rst || (state != WAIT)) begin
         wd_cnt <= '0;
      end else if (!timeout_hit) begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end

   assign timeout_hit = (state == WAIT) && !done_ok && (wd_cnt == WD_LAST);
`else
   logic [31:0] unused_timeout_cfg;
   assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
   assign timeout_hit        = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (any_req) state_nxt = START;
         end
         START: begin
            if (!bus.spi_busy) state_nxt = WAIT;
         end
         WAIT: begin
            if (done_ok || timeout_hit) begin
               state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
            end
         end
         GAP: begin
            if (gap_cnt == GAP_LAST) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FSM output logic: next values of the registered outputs and datapath.
   always_comb begin
      grant_nxt = grant_reg;
      ack_nxt   = '0;
      start_nxt = 1'b0;
      err_nxt   = 1'b0;
      data_nxt  = data_reg;
      cur_nxt   = cur_reg;
      last_nxt  = last_reg;
      gap_nxt   = gap_cnt;
      case (state)
         IDLE: begin
            if (any_req) begin
               grant_nxt = NUM_REQ'(1) << win_idx;
               data_nxt  = bus.req_data[int'(win_idx)*DATA_W +: DATA_W];
               cur_nxt   = win_idx;
            end
         end
         START: begin
            if (!bus.spi_busy) start_nxt = 1'b1;
         end
         WAIT: begin
            if (done_ok) begin
               // grant is one-hot on cur, so it doubles as the ack vector
               ack_nxt   = grant_reg;
               grant_nxt = '0;
               last_nxt  = cur_reg;
               gap_nxt   = '0;
            end else if (timeout_hit) begin
               err_nxt   = 1'b1;
               grant_nxt = '0;
               last_nxt  = cur_reg;
               gap_nxt   = '0;
            end
         end
         GAP: begin
            gap_nxt = gap_cnt + 1'b1;
         end
         default: begin
            grant_nxt = '0;
         end
      endcase
   end

   // Output and datapath registers; reset aborts any transaction silently.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_reg <= '0;
         ack_reg   <= '0;
         start_reg <= 1'b0;
         err_reg   <= 1'b0;
         data_reg  <= '0;
         cur_reg   <= '0;
         last_reg  <= IDX_LAST;
         gap_cnt   <= '0;
      end else begin
         grant_reg <= grant_nxt;
         ack_reg   <= ack_nxt;
         start_reg <= start_nxt;
         err_reg   <= err_nxt;
         data_reg  <= data_nxt;
         cur_reg   <= cur_nxt;
         last_reg  <= last_nxt;
         gap_cnt   <= gap_nxt;
      end
   end

   assign bus.grant     = grant_reg;
   assign bus.ack       = ack_reg;
   assign bus.spi_start = start_reg;
   assign bus.spi_data  = data_reg;
   assign bus.err       = err_reg;
   assign bus.arb_busy  = (state != IDLE);

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter (NUM_REQ=4, DATA_W=12, GAP_CYCLES=200,
// TIMEOUT_CYCLES=100). Build with +define+TIMEOUT_EN to include the
// watchdog scenario.
module tb_spi_req_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 12;
   localparam int GAP     = 200;

   logic clk;
   logic rst;

   int n_chk;
   int n_err;

   spi_req_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

   spi_req_arbiter #(
      .NUM_REQ        (NUM_REQ),
      .DATA_W         (DATA_W),
      .GAP_CYCLES     (GAP),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // advance one clock; inputs are driven and outputs sampled 1ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_start(input int limit, output int n);
      n = 0;
      while ((bus.spi_start !== 1'b1) && (n < limit)) begin
         tick();
         n++;
      end
      if (bus.spi_start !== 1'b1) check_val("start_wait", 32'(bus.spi_start), 32'd1);
   endtask

   task automatic wait_idle(input int limit, output int n);
      n = 0;
      while ((bus.arb_busy !== 1'b0) && (n < limit)) begin
         tick();
         n++;
      end
      if (bus.arb_busy !== 1'b0) check_val("idle_wait", 32'(bus.arb_busy), 32'd0);
   endtask

   // engine model: busy from start, done pulse dur cycles later; ends on the ack cycle
   task automatic finish_txn(input int dur, input logic [NUM_REQ-1:0] exp_ack);
      bus.spi_busy = 1'b1;
      repeat (dur - 1) tick();
      bus.spi_done = 1'b1;
      bus.spi_busy = 1'b0;
      tick();
      check_val("ack", 32'(bus.ack), 32'(exp_ack));
      check_val("grant_clr", 32'(bus.grant), 32'd0);
      bus.spi_done = 1'b0;
   endtask

   task automatic serve(input string tag, input int limit, input int exp_wait,
                        input logic [NUM_REQ-1:0] exp_grant, input logic [DATA_W-1:0] exp_data);
      int n;
      wait_start(limit, n);
      if (exp_wait >= 0) check_val({tag, "_wait"}, 32'(n), 32'(exp_wait));
      check_val({tag, "_grant"}, 32'(bus.grant), 32'(exp_grant));
      check_val({tag, "_data"}, 32'(bus.spi_data), 32'(exp_data));
      finish_txn(5, exp_grant);
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_grant"}, 32'(bus.grant), 32'd0);
      check_val({tag, "_ack"}, 32'(bus.ack), 32'd0);
      check_val({tag, "_start"}, 32'(bus.spi_start), 32'd0);
      check_val({tag, "_data"}, 32'(bus.spi_data), 32'd0);
      check_val({tag, "_busy"}, 32'(bus.arb_busy), 32'd0);
      check_val({tag, "_err"}, 32'(bus.err), 32'd0);
   endtask

   initial begin
      int n;
      logic early;
      n_chk = 0;
      n_err = 0;
      rst          = 1'b1;
      bus.req      = '0;
      bus.req_data = '0;
      bus.spi_busy = 1'b0;
      bus.spi_done = 1'b0;

      // reset state
      tick();
      tick();
      check_all_zero("reset");

      // single request: latency, data, 40-cycle engine, ack, exact gap length
      rst          = 1'b0;
      bus.req      = 4'b0001;
      bus.req_data = {12'h000, 12'h000, 12'h000, 12'h925};
      tick();
      check_val("t1_grant", 32'(bus.grant), 32'h1);
      check_val("t1_data", 32'(bus.spi_data), 32'h925);
      check_val("t1_start_early", 32'(bus.spi_start), 32'd0);
      check_val("t1_busy", 32'(bus.arb_busy), 32'd1);
      tick();
      check_val("t1_start", 32'(bus.spi_start), 32'd1);
      finish_txn(40, 4'b0001);
      bus.req = '0;
      tick();
      check_val("t1_ack_pulse", 32'(bus.ack), 32'd0);
      check_val("t1_gap_busy", 32'(bus.arb_busy), 32'd1);
      n = 1;
      while ((bus.arb_busy !== 1'b0) && (n < 400)) begin
         tick();
         n++;
      end
      check_val("t1_gap_len", 32'(n), 32'd200);

      // four simultaneous requests from a fresh reset: order 0,1,2,3, gap enforced
      rst = 1'b1;
      tick();
      rst          = 1'b0;
      bus.req      = 4'b1111;
      bus.req_data = {12'hD34, 12'hC23, 12'hB12, 12'hA01};
      serve("t2_r0", 10, 2, 4'b0001, 12'hA01);
      bus.req[0] = 1'b0;
      serve("t2_r1", 400, 202, 4'b0010, 12'hB12);
      bus.req[1] = 1'b0;
      serve("t2_r2", 400, 202, 4'b0100, 12'hC23);
      bus.req[2] = 1'b0;
      serve("t2_r3", 400, 202, 4'b1000, 12'hD34);
      bus.req[3] = 1'b0;

      // req0 and req2 kept asserted: grants alternate 0,2,0,2
      bus.req = 4'b0101;
      serve("t3_a", 400, -1, 4'b0001, 12'hA01);
      serve("t3_b", 400, -1, 4'b0100, 12'hC23);
      serve("t3_c", 400, -1, 4'b0001, 12'hA01);
      serve("t3_d", 400, -1, 4'b0100, 12'hC23);
      bus.req = '0;
      wait_idle(400, n);

      // engine busy for 10 cycles after grant; start held back, one pulse,
      // and a done in the start cycle is ignored
      bus.spi_busy = 1'b1;
      bus.req      = 4'b0010;
      bus.req_data = {12'h000, 12'h000, 12'h5A5, 12'h000};
      tick();
      check_val("t4_grant", 32'(bus.grant), 32'h2);
      early = 1'b0;
      repeat (10) begin
         tick();
         early = early | bus.spi_start;
      end
      check_val("t4_no_early_start", 32'(early), 32'd0);
      bus.spi_busy = 1'b0;
      tick();
      check_val("t4_start", 32'(bus.spi_start), 32'd1);
      bus.spi_done = 1'b1;
      tick();
      bus.spi_done = 1'b0;
      check_val("t4_start_once", 32'(bus.spi_start), 32'd0);
      check_val("t4_done_ignored", 32'(bus.ack), 32'd0);
      check_val("t4_grant_held", 32'(bus.grant), 32'h2);
      check_val("t4_data", 32'(bus.spi_data), 32'h5A5);
      finish_txn(10, 4'b0010);
      bus.req = '0;
      wait_idle(400, n);

      // reset in the middle of WAIT: everything cleared, no ack, priority back to 0
      bus.req      = 4'b1000;
      bus.req_data = {12'h3C3, 12'h000, 12'h000, 12'h7E1};
      wait_start(10, n);
      check_val("t5_lat", 32'(n), 32'd2);
      bus.spi_busy = 1'b1;
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst     = 1'b0;
      bus.req = '0;
      check_all_zero("t5_rst");
      bus.spi_busy = 1'b0;
      bus.spi_done = 1'b1;
      tick();
      bus.spi_done = 1'b0;
      check_val("t5_no_ack", 32'(bus.ack), 32'd0);
      check_val("t5_idle", 32'(bus.arb_busy), 32'd0);
      bus.req = 4'b1001;
      tick();
      check_val("t5_next_grant", 32'(bus.grant), 32'h1);
      serve("t5_r0", 10, 1, 4'b0001, 12'h7E1);
      bus.req = '0;
      wait_idle(400, n);
      check_val("t5_err_low", 32'(bus.err), 32'd0);

`ifdef TIMEOUT_EN
      // watchdog: no done, err after 100 WAIT cycles, no ack, next requester served
      bus.req      = 4'b0110;
      bus.req_data = {12'h000, 12'h0B2, 12'h0A1, 12'h000};
      wait_start(10, n);
      check_val("t6_grant", 32'(bus.grant), 32'h2);
      bus.spi_busy = 1'b1;
      n = 0;
      while ((bus.err !== 1'b1) && (n < 300)) begin
         tick();
         n++;
      end
      check_val("t6_err_time", 32'(n), 32'd100);
      check_val("t6_grant_clr", 32'(bus.grant), 32'd0);
      check_val("t6_no_ack", 32'(bus.ack), 32'd0);
      bus.req      = 4'b0100;
      bus.spi_busy = 1'b0;
      tick();
      check_val("t6_err_pulse", 32'(bus.err), 32'd0);
      serve("t6_next", 400, 201, 4'b0100, 12'h0B2);
      bus.req = '0;
      wait_idle(400, n);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
